// File: rtl/cachemem_assoc_pkg.sv
// Shared cache definitions: geometry defaults used by the I-cache and D-cache,
// the flush sequencer state encoding and the log2 helper.
`ifndef SD
`define SD
`endif

package cachemem_assoc_pkg;

   localparam int DEF_DATA_SIZE = 64;
   localparam int DEF_SETS      = 32;
   localparam int DEF_WAYS      = 4;
   localparam int DEF_TAG_BITS  = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } flush_state_t;

   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Vector width able to hold a way number; a direct-mapped cache still needs one bit.
   function automatic int width_of(input int n);
      return (log2(n) > 0) ? log2(n) : 1;
   endfunction

endpackage

// File: rtl/cachemem_lru.sv
// True-LRU age vector for one set: ages form a permutation of 0..WAYS-1, 0 = MRU.
`ifndef SD
`define SD
`endif

module cachemem_lru
   import cachemem_assoc_pkg::*;
#(
   parameter  int WAYS  = DEF_WAYS,
   localparam int WAY_W = width_of(WAYS)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             touch_en,
   input  logic [WAY_W-1:0] touch_way,
   input  logic             init,
   output logic [WAY_W-1:0] lru_way
);

   logic [WAY_W-1:0] age [WAYS];
   logic [WAY_W-1:0] touched_age;

   always_comb begin
      touched_age = '0;
      lru_way     = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == touch_way) touched_age = age[w];
         if (age[w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < WAYS; w++) age[w] <= `SD WAY_W'(w);
      end else if (init) begin
         for (int w = 0; w < WAYS; w++) age[w] <= `SD WAY_W'(w);
      end else if (touch_en) begin
         // Younger-than-touched ways age by one; the touched way becomes MRU.
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) age[w] <= `SD '0;
            else if (age[w] < touched_age) age[w] <= `SD age[w] + WAY_W'(1);
         end
      end
   end

endmodule

// File: rtl/cachemem_assoc.sv
// N-way set-associative cache storage: combinational lookup, LRU fill,
// per-line invalidate and a set-by-set flush sequencer.
`ifndef SD
`define SD
`endif

module cachemem_assoc
   import cachemem_assoc_pkg::*;
#(
   parameter  int DATA_SIZE = DEF_DATA_SIZE,
   parameter  int SETS      = DEF_SETS,
   parameter  int WAYS      = DEF_WAYS,
   parameter  int TAG_BITS  = DEF_TAG_BITS,
   localparam int IDX_BITS  = log2(SETS),
   localparam int WAY_W     = width_of(WAYS)
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rd1_en,
   input  logic [IDX_BITS-1:0]  rd1_idx,
   input  logic [TAG_BITS-1:0]  rd1_tag,
   output logic [DATA_SIZE-1:0] rd1_data,
   output logic                 rd1_valid,
   output logic [WAY_W-1:0]     rd1_way,
   input  logic                 wr1_en,
   input  logic [IDX_BITS-1:0]  wr1_idx,
   input  logic [TAG_BITS-1:0]  wr1_tag,
   input  logic [DATA_SIZE-1:0] wr1_data,
   output logic [WAY_W-1:0]     wr1_way,
   output logic                 wr1_evict,
   input  logic                 inv_en,
   input  logic [IDX_BITS-1:0]  inv_idx,
   input  logic [TAG_BITS-1:0]  inv_tag,
   input  logic                 flush_req,
   output logic                 flush_busy,
   output logic                 flush_done
);

   localparam logic [IDX_BITS-1:0] LAST_SET = IDX_BITS'(SETS - 1);

   logic [DATA_SIZE-1:0] data_mem [SETS][WAYS];
   logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
   logic [WAYS-1:0]      valid_q  [SETS];

   flush_state_t         state, state_nxt;
   logic [IDX_BITS-1:0]  cnt;
   logic                 flushing;

   logic [WAY_W-1:0]     lru_way   [SETS];
   logic [WAY_W-1:0]     touch_way [SETS];
   logic [SETS-1:0]      touch_en;
   logic [SETS-1:0]      init;

   logic                 rd_hit;
   logic [WAY_W-1:0]     rd_hit_way;
   logic [DATA_SIZE-1:0] rd_hit_data;
   logic                 wr_match, wr_free;
   logic [WAY_W-1:0]     wr_match_way, wr_free_way, fill_way;
   logic                 fill_fire, inv_fire, rd_touch;

   // ---------------- lookup ----------------
   always_comb begin
      rd_hit      = 1'b0;
      rd_hit_way  = '0;
      rd_hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[rd1_idx][w] && (tag_mem[rd1_idx][w] == rd1_tag)) begin
            rd_hit      = 1'b1;
            rd_hit_way  = WAY_W'(w);
            rd_hit_data = data_mem[rd1_idx][w];
         end
      end
   end

   assign rd1_valid = rd_hit && !flushing;
   assign rd1_way   = rd1_valid ? rd_hit_way  : '0;
   assign rd1_data  = rd1_valid ? rd_hit_data : '0;

   // ---------------- fill victim selection ----------------
   // Descending scan so the lowest-index invalid way is the one left standing.
   always_comb begin
      wr_match     = 1'b0;
      wr_match_way = '0;
      wr_free      = 1'b0;
      wr_free_way  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[wr1_idx][w] && (tag_mem[wr1_idx][w] == wr1_tag)) begin
            wr_match     = 1'b1;
            wr_match_way = WAY_W'(w);
         end
         if (!valid_q[wr1_idx][w]) begin
            wr_free     = 1'b1;
            wr_free_way = WAY_W'(w);
         end
      end
      if (wr_match)     fill_way = wr_match_way;
      else if (wr_free) fill_way = wr_free_way;
      else              fill_way = lru_way[wr1_idx];
   end

   assign wr1_way   = flushing ? '0 : fill_way;
   assign wr1_evict = !flushing && !wr_match && !wr_free;

   assign fill_fire = wr1_en && !flushing;
   assign inv_fire  = inv_en && !flushing;
   assign rd_touch  = rd1_en && rd1_valid;

   // ---------------- per-set LRU ----------------
   for (genvar s = 0; s < SETS; s++) begin : g_set
      logic fill_here, rd_here;
      assign fill_here    = fill_fire && (wr1_idx == IDX_BITS'(s));
      assign rd_here      = rd_touch  && (rd1_idx == IDX_BITS'(s));
      // A fill to the same set overrides the read touch.
      assign touch_en[s]  = fill_here || rd_here;
      assign touch_way[s] = fill_here ? fill_way : rd1_way;
      assign init[s]      = flushing && (cnt == IDX_BITS'(s));

      cachemem_lru #(.WAYS(WAYS)) u_lru (
         .clock     (clock),
         .reset     (reset),
         .touch_en  (touch_en[s]),
         .touch_way (touch_way[s]),
         .init      (init[s]),
         .lru_way   (lru_way[s])
      );
   end

   // ---------------- valid bits ----------------
   // Fill is applied after invalidate so it wins on a same-line collision.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) valid_q[s] <= `SD '0;
      end else if (flushing) begin
         valid_q[cnt] <= `SD '0;
      end else begin
         if (inv_fire) begin
            for (int w = 0; w < WAYS; w++)
               if (valid_q[inv_idx][w] && (tag_mem[inv_idx][w] == inv_tag))
                  valid_q[inv_idx][w] <= `SD 1'b0;
         end
         if (fill_fire) begin
            for (int w = 0; w < WAYS; w++)
               if (WAY_W'(w) == fill_way) valid_q[wr1_idx][w] <= `SD 1'b1;
         end
      end
   end

   // Data and tag arrays carry no reset; valid bits gate every use.
   always_ff @(posedge clock) begin
      if (fill_fire) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == fill_way) begin
               data_mem[wr1_idx][w] <= `SD wr1_data;
               tag_mem[wr1_idx][w]  <= `SD wr1_tag;
            end
         end
      end
   end

   // ---------------- flush sequencer ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= `SD ST_IDLE;
         cnt   <= `SD '0;
      end else begin
         state <= `SD state_nxt;
         cnt   <= `SD (state == ST_FLUSH) ? cnt + IDX_BITS'(1) : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (flush_req)        state_nxt = ST_FLUSH;
         ST_FLUSH: if (cnt == LAST_SET)  state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      flushing   = (state == ST_FLUSH);
      flush_busy = flushing;
      flush_done = flushing && (cnt == LAST_SET);
   end

endmodule

// File: tb/tb_cachemem_assoc.sv
// Bench for cachemem_assoc: directed scenarios plus random traffic checked
// against a recency-timestamp model of the cache.
module tb_cachemem_assoc;
   import cachemem_assoc_pkg::*;

   localparam int DW = 64, SETS = 32, WAYS = 4, TW = 8, IW = 5, WW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          rd1_en, wr1_en, inv_en, flush_req;
   logic [IW-1:0] rd1_idx, wr1_idx, inv_idx;
   logic [TW-1:0] rd1_tag, wr1_tag, inv_tag;
   logic [DW-1:0] wr1_data, rd1_data;
   logic          rd1_valid, wr1_evict, flush_busy, flush_done;
   logic [WW-1:0] rd1_way, wr1_way;

   cachemem_assoc dut (
      .clock(clock), .reset(reset),
      .rd1_en(rd1_en), .rd1_idx(rd1_idx), .rd1_tag(rd1_tag),
      .rd1_data(rd1_data), .rd1_valid(rd1_valid), .rd1_way(rd1_way),
      .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data),
      .wr1_way(wr1_way), .wr1_evict(wr1_evict),
      .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag),
      .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   bit            m_valid [SETS][WAYS];
   logic [TW-1:0] m_tag   [SETS][WAYS];
   logic [DW-1:0] m_data  [SETS][WAYS];
   int            m_stamp [SETS][WAYS];  // larger = more recently used
   int            m_time = 0;
   int            flush_left = 0, flush_set = 0;

   logic          e_rd_valid, e_evict, e_busy, e_done;
   logic [WW-1:0] e_rd_way, e_wr_way;
   logic [DW-1:0] e_rd_data;

   int n_checks = 0, n_pass = 0;

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_stamp[s][w] = -w;
         end
      flush_left = 0;
      flush_set  = 0;
   endfunction

   function automatic void predict();
      int lru;
      bit found;
      e_busy = (flush_left > 0);
      e_done = (flush_left == 1);
      e_rd_valid = 1'b0; e_rd_way = '0; e_rd_data = '0;
      e_wr_way = '0; e_evict = 1'b0;
      if (!e_busy) begin
         for (int w = 0; w < WAYS; w++)
            if (m_valid[rd1_idx][w] && m_tag[rd1_idx][w] == rd1_tag) begin
               e_rd_valid = 1'b1; e_rd_way = WW'(w); e_rd_data = m_data[rd1_idx][w];
            end
         found = 1'b0;
         for (int w = 0; w < WAYS; w++)
            if (!found && m_valid[wr1_idx][w] && m_tag[wr1_idx][w] == wr1_tag) begin
               found = 1'b1; e_wr_way = WW'(w);
            end
         for (int w = 0; w < WAYS; w++)
            if (!found && !m_valid[wr1_idx][w]) begin
               found = 1'b1; e_wr_way = WW'(w);
            end
         if (!found) begin
            lru = 0;
            for (int w = 1; w < WAYS; w++)
               if (m_stamp[wr1_idx][w] < m_stamp[wr1_idx][lru]) lru = w;
            e_wr_way = WW'(lru);
            e_evict  = 1'b1;
         end
      end
   endfunction

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      predict();
      @(posedge clock);
      if (flush_left > 0) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[flush_set][w] = 1'b0;
            m_stamp[flush_set][w] = -w;
         end
         flush_set++;
         flush_left--;
      end else begin
         if (rd1_en && e_rd_valid && !(wr1_en && wr1_idx == rd1_idx))
            m_stamp[rd1_idx][e_rd_way] = ++m_time;
         if (inv_en)
            for (int w = 0; w < WAYS; w++)
               if (m_valid[inv_idx][w] && m_tag[inv_idx][w] == inv_tag) m_valid[inv_idx][w] = 1'b0;
         if (wr1_en) begin
            m_valid[wr1_idx][e_wr_way] = 1'b1;
            m_tag[wr1_idx][e_wr_way]   = wr1_tag;
            m_data[wr1_idx][e_wr_way]  = wr1_data;
            m_stamp[wr1_idx][e_wr_way] = ++m_time;
         end
         if (flush_req) begin
            flush_left = SETS;
            flush_set  = 0;
         end
      end
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic drive_idle();
      rd1_en = 0; rd1_idx = '0; rd1_tag = '0;
      wr1_en = 0; wr1_idx = '0; wr1_tag = '0; wr1_data = '0;
      inv_en = 0; inv_idx = '0; inv_tag = '0;
      flush_req = 0;
   endtask

   task automatic do_fill(input int idx, input int tag, input logic [DW-1:0] d);
      drive_idle();
      wr1_en = 1; wr1_idx = IW'(idx); wr1_tag = TW'(tag); wr1_data = d;
      tick();
      drive_idle();
   endtask

   task automatic do_read(input int idx, input int tag);
      drive_idle();
      rd1_en = 1; rd1_idx = IW'(idx); rd1_tag = TW'(tag);
      tick();
      drive_idle();
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      model_reset();
      rd1_idx = 5'd3; rd1_tag = 8'h11;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b0 || rd1_data !== '0 || rd1_way !== '0) $display("FAIL reset_lookup: valid=%0b data=%0h way=%0d expected 0/0/0", rd1_valid, rd1_data, rd1_way); else n_pass++;
      n_checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0 || wr1_evict !== 1'b0) $display("FAIL reset_flags: busy=%0b done=%0b evict=%0b expected 0/0/0", flush_busy, flush_done, wr1_evict); else n_pass++;
      reset = 1'b1;
      tick();
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b0 || flush_busy !== 1'b0) $display("FAIL post_reset: valid=%0b busy=%0b expected 0/0", rd1_valid, flush_busy); else n_pass++;
   endtask

   task automatic test_fill_set();
      for (int i = 0; i < 4; i++) begin
         drive_idle();
         wr1_en = 1; wr1_idx = 5'd5; wr1_tag = TW'(8'hA0 + i); wr1_data = rand_data();
         @(negedge clock);
         n_checks++; if (wr1_way !== WW'(i) || wr1_evict !== 1'b0) $display("FAIL fill_way[%0d]: way=%0d evict=%0b expected %0d/0", i, wr1_way, wr1_evict, i); else n_pass++;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive_idle();
         rd1_idx = 5'd5; rd1_tag = TW'(8'hA0 + i);
         @(negedge clock);
         n_checks++; if (rd1_valid !== 1'b1 || rd1_way !== WW'(i) || rd1_data !== m_data[5][i]) $display("FAIL fill_hit[%0d]: valid=%0b way=%0d data=%0h expected 1/%0d/%0h", i, rd1_valid, rd1_way, rd1_data, i, m_data[5][i]); else n_pass++;
         tick();
      end
   endtask

   task automatic test_lru_evict();
      do_read(5, 8'hA0);
      wr1_en = 1; wr1_idx = 5'd5; wr1_tag = 8'hB0; wr1_data = rand_data();
      @(negedge clock);
      n_checks++; if (wr1_way !== 2'd1 || wr1_evict !== 1'b1) $display("FAIL lru_victim: way=%0d evict=%0b expected 1/1", wr1_way, wr1_evict); else n_pass++;
      tick();
      drive_idle();
      rd1_idx = 5'd5; rd1_tag = 8'hA1;
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b0) $display("FAIL evicted_miss: valid=%0b expected 0", rd1_valid); else n_pass++;
      tick();
   endtask

   task automatic test_refill();
      logic [DW-1:0] d;
      d = rand_data();
      wr1_en = 1; wr1_idx = 5'd5; wr1_tag = 8'hA2; wr1_data = d;
      @(negedge clock);
      n_checks++; if (wr1_way !== 2'd2 || wr1_evict !== 1'b0) $display("FAIL refill_way: way=%0d evict=%0b expected 2/0", wr1_way, wr1_evict); else n_pass++;
      tick();
      drive_idle();
      rd1_idx = 5'd5; rd1_tag = 8'hA2;
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== d) $display("FAIL refill_data: valid=%0b data=%0h expected 1/%0h", rd1_valid, rd1_data, d); else n_pass++;
      tick();
   endtask

   task automatic test_invalidate();
      do_read(5, 8'hA3);  // way 3 becomes MRU, way 0 is now the LRU
      inv_en = 1; inv_idx = 5'd5; inv_tag = 8'h77;
      tick();
      drive_idle();
      rd1_idx = 5'd5; rd1_tag = 8'hA0;
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b1) $display("FAIL inv_miss_noop: valid=%0b expected 1", rd1_valid); else n_pass++;
      inv_en = 1; inv_idx = 5'd5; inv_tag = 8'hA3;
      tick();
      drive_idle();
      wr1_en = 1; wr1_idx = 5'd5; wr1_tag = 8'hC0; wr1_data = rand_data();
      @(negedge clock);
      n_checks++; if (wr1_way !== 2'd3 || wr1_evict !== 1'b0) $display("FAIL inv_reuse: way=%0d evict=%0b expected 3/0", wr1_way, wr1_evict); else n_pass++;
      tick();
      // invalidate and fill of the same line in one cycle: fill survives
      drive_idle();
      wr1_en = 1; wr1_idx = 5'd5; wr1_tag = 8'hC0; wr1_data = rand_data();
      inv_en = 1; inv_idx = 5'd5; inv_tag = 8'hC0;
      tick();
      drive_idle();
      rd1_idx = 5'd5; rd1_tag = 8'hC0;
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== m_data[5][3]) $display("FAIL inv_fill_collide: valid=%0b data=%0h expected 1/%0h", rd1_valid, rd1_data, m_data[5][3]); else n_pass++;
      tick();
   endtask

   task automatic test_read_during_fill();
      logic [DW-1:0] old_d;
      old_d = m_data[5][0];
      drive_idle();
      rd1_en = 1; rd1_idx = 5'd5; rd1_tag = 8'hA0;
      wr1_en = 1; wr1_idx = 5'd5; wr1_tag = 8'hA0; wr1_data = ~old_d;
      @(negedge clock);
      n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== old_d) $display("FAIL read_prefill: valid=%0b data=%0h expected 1/%0h", rd1_valid, rd1_data, old_d); else n_pass++;
      tick();
      drive_idle();
      rd1_idx = 5'd5; rd1_tag = 8'hA0;
      @(negedge clock);
      n_checks++; if (rd1_data !== ~old_d) $display("FAIL read_postfill: data=%0h expected %0h", rd1_data, ~old_d); else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      int busy_cycles = 0, done_cycle = -1, done_count = 0;
      int sets [4] = '{0, 7, 12, 31};
      foreach (sets[k]) do_fill(sets[k], 8'h30 + k, rand_data());
      flush_req = 1;
      tick();
      flush_req = 0;
      for (int c = 0; c < SETS + 3; c++) begin
         drive_idle();
         if (c == 3) begin
            wr1_en = 1; wr1_idx = 5'd9; wr1_tag = 8'h5A; wr1_data = rand_data();
            rd1_idx = 5'd31; rd1_tag = 8'h33;
         end
         @(negedge clock);
         predict();
         if (flush_busy === 1'b1) busy_cycles++;
         if (flush_done === 1'b1) begin done_cycle = c; done_count++; end
         n_checks++; if (flush_busy !== e_busy || flush_done !== e_done) $display("FAIL flush_cycle[%0d]: busy=%0b done=%0b expected %0b/%0b", c, flush_busy, flush_done, e_busy, e_done); else n_pass++;
         if (c == 3) begin
            n_checks++; if (wr1_way !== '0 || wr1_evict !== 1'b0 || rd1_valid !== 1'b0) $display("FAIL flush_ignore: way=%0d evict=%0b valid=%0b expected 0/0/0", wr1_way, wr1_evict, rd1_valid); else n_pass++;
         end
         tick();
      end
      n_checks++; if (busy_cycles != 32 || done_cycle != 31 || done_count != 1) $display("FAIL flush_len: busy=%0d done_at=%0d done_n=%0d expected 32/31/1", busy_cycles, done_cycle, done_count); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         drive_idle();
         rd1_idx = (k < 4) ? IW'(sets[k]) : 5'd9;
         rd1_tag = (k < 4) ? TW'(8'h30 + k) : 8'h5A;
         @(negedge clock);
         n_checks++; if (rd1_valid !== 1'b0) $display("FAIL post_flush_miss[%0d]: valid=%0b expected 0", k, rd1_valid); else n_pass++;
         tick();
      end
   endtask

   task automatic test_reset_mid_flush();
      int done_count = 0;
      do_fill(2, 8'h44, rand_data());
      flush_req = 1;
      tick();
      flush_req = 0;
      repeat (10) tick();
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL reset_abort: busy=%0b done=%0b expected 0/0", flush_busy, flush_done); else n_pass++;
      #1 reset = 1'b1;
      for (int c = 0; c < SETS + 2; c++) begin
         @(negedge clock);
         if (flush_done === 1'b1 || flush_busy === 1'b1) done_count++;
         tick();
      end
      n_checks++; if (done_count != 0) $display("FAIL reset_no_done: busy/done cycles=%0d expected 0", done_count); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         drive_idle();
         rd1_en = 1'($urandom_range(0, 1)); rd1_idx = IW'($urandom_range(0, 3)); rd1_tag = TW'($urandom_range(0, 7));
         wr1_en = ($urandom_range(0, 1) == 1); wr1_idx = IW'($urandom_range(0, 3)); wr1_tag = TW'($urandom_range(0, 7));
         wr1_data = rand_data();
         inv_en = ($urandom_range(0, 4) == 0); inv_idx = IW'($urandom_range(0, 3)); inv_tag = TW'($urandom_range(0, 7));
         flush_req = ($urandom_range(0, 299) == 0);
         @(negedge clock);
         predict();
         n_checks++; if (rd1_valid !== e_rd_valid || rd1_way !== e_rd_way) $display("FAIL rnd_lookup[%0d]: valid=%0b way=%0d expected %0b/%0d", c, rd1_valid, rd1_way, e_rd_valid, e_rd_way); else n_pass++;
         n_checks++; if (rd1_data !== e_rd_data) $display("FAIL rnd_data[%0d]: got %0h expected %0h", c, rd1_data, e_rd_data); else n_pass++;
         n_checks++; if (wr1_way !== e_wr_way || wr1_evict !== e_evict) $display("FAIL rnd_victim[%0d]: way=%0d evict=%0b expected %0d/%0b", c, wr1_way, wr1_evict, e_wr_way, e_evict); else n_pass++;
         n_checks++; if (flush_busy !== e_busy || flush_done !== e_done) $display("FAIL rnd_flush[%0d]: busy=%0b done=%0b expected %0b/%0b", c, flush_busy, flush_done, e_busy, e_done); else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill_set();
      test_lru_evict();
      test_refill();
      test_invalidate();
      test_read_during_fill();
      test_flush();
      test_reset_mid_flush();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
